// File: rtl/dec_seq.sv
// ADC/SBC sequencer driving a combinational ALU: one pass for binary mode,
// and a second correction pass for decimal (BCD) mode.
module dec_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sbc,
    input  logic       dec,
    input  logic [7:0] a_in,
    input  logic [7:0] m_in,
    input  logic       c_in,
    input  logic       abort,
    output logic [7:0] alu_ai,
    output logic [7:0] alu_mi,
    output logic       alu_ci,
    output logic       alu_mem_bi,
    output logic       alu_inv_bi,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_out,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       alu_hc,
    input  logic       alu_dhc,
    input  logic       alu_dc,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       c_out,
    output logic       n_out,
    output logic       v_out,
    output logic       z_out
);

    localparam logic [2:0] ALU_AI  = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;

    typedef enum logic [1:0] {IDLE, BIN, ADJ} state_t;

    state_t     state_q;
    logic       sbc_q, dec_q, c_q;
    logic [7:0] a_q, m_q, s_q;
    logic       cb_q, vb_q, hcb_q, dhcb_q, dcb_q;
    logic       busy_q, done_q;
    logic [7:0] result_q;
    logic       c_out_q, n_out_q, v_out_q, z_out_q;
    logic [7:0] adj_k;
    logic       adj_c;

    // Decimal correction constant; SBC uses the two's complement of 06/60/66.
    function automatic logic [7:0] corr_k(input logic is_sbc, input logic hc,
                                          input logic dhc, input logic c,
                                          input logic dc);
        logic       lo, hi;
        logic [7:0] k;
        if (is_sbc) begin
            lo = ~hc;
            hi = ~c;
            case ({hi, lo})
                2'b00:   k = 8'h00;
                2'b01:   k = 8'hFA;
                2'b10:   k = 8'hA0;
                default: k = 8'h9A;
            endcase
        end else begin
            lo = hc | dhc;
            hi = c | dc;
            k  = {1'b0, hi, hi, 1'b0, 1'b0, lo, lo, 1'b0};
        end
        return k;
    endfunction

    function automatic logic corr_c(input logic is_sbc, input logic c, input logic dc);
        return is_sbc ? c : (c | dc);
    endfunction

    assign adj_k = corr_k(sbc_q, hcb_q, dhcb_q, cb_q, dcb_q);
    assign adj_c = corr_c(sbc_q, cb_q, dcb_q);

    always_comb begin
        alu_op     = ALU_AI;
        alu_ai     = 8'h00;
        alu_mi     = 8'h00;
        alu_ci     = 1'b0;
        alu_mem_bi = 1'b0;
        alu_inv_bi = 1'b0;
        case (state_q)
            BIN: begin
                alu_op     = ALU_ADC;
                alu_ai     = a_q;
                alu_mi     = m_q;
                alu_ci     = c_q;
                alu_mem_bi = 1'b1;
                alu_inv_bi = sbc_q;
            end
            ADJ: begin
                alu_op     = ALU_ADC;
                alu_ai     = s_q;
                alu_mi     = adj_k;
                alu_mem_bi = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sbc_q    <= 1'b0;
            dec_q    <= 1'b0;
            c_q      <= 1'b0;
            a_q      <= 8'h00;
            m_q      <= 8'h00;
            s_q      <= 8'h00;
            cb_q     <= 1'b0;
            vb_q     <= 1'b0;
            hcb_q    <= 1'b0;
            dhcb_q   <= 1'b0;
            dcb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
            c_out_q  <= 1'b0;
            n_out_q  <= 1'b0;
            v_out_q  <= 1'b0;
            z_out_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        sbc_q   <= sbc;
                        dec_q   <= dec;
                        a_q     <= a_in;
                        m_q     <= m_in;
                        c_q     <= c_in;
                        busy_q  <= 1'b1;
                        state_q <= BIN;
                    end
                    BIN: begin
                        s_q    <= alu_out;
                        cb_q   <= alu_c;
                        vb_q   <= alu_v;
                        hcb_q  <= alu_hc;
                        dhcb_q <= alu_dhc;
                        dcb_q  <= alu_dc;
                        if (dec_q) begin
                            state_q <= ADJ;
                        end else begin
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= alu_out;
                            c_out_q  <= alu_c;
                            v_out_q  <= alu_v;
                            n_out_q  <= alu_out[7];
                            z_out_q  <= (alu_out == 8'h00);
                        end
                    end
                    ADJ: begin
                        // The carry of this pass is meaningless; the decimal carry was fixed in BIN.
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= alu_out;
                        c_out_q  <= adj_c;
                        v_out_q  <= vb_q;
                        n_out_q  <= alu_out[7];
                        z_out_q  <= (alu_out == 8'h00);
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign c_out  = c_out_q;
    assign n_out  = n_out_q;
    assign v_out  = v_out_q;
    assign z_out  = z_out_q;

endmodule

// File: tb/tb_dec_seq.sv
// Bench for dec_seq: behavioural ALU, digit-wise BCD reference model and a result scoreboard.
module tb_dec_seq;

    localparam logic [2:0] ALU_AI  = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;

    logic       clk = 1'b0;
    logic       rst_n, start, sbc, dec, c_in, abort;
    logic [7:0] a_in, m_in;
    logic [7:0] alu_ai, alu_mi, alu_out;
    logic       alu_ci, alu_mem_bi, alu_inv_bi;
    logic [2:0] alu_op;
    logic       alu_c, alu_v, alu_hc, alu_dhc, alu_dc;
    logic       busy, done, c_out, n_out, v_out, z_out;
    logic [7:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    dec_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sbc(sbc), .dec(dec),
        .a_in(a_in), .m_in(m_in), .c_in(c_in), .abort(abort),
        .alu_ai(alu_ai), .alu_mi(alu_mi), .alu_ci(alu_ci),
        .alu_mem_bi(alu_mem_bi), .alu_inv_bi(alu_inv_bi), .alu_op(alu_op),
        .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v), .alu_hc(alu_hc),
        .alu_dhc(alu_dhc), .alu_dc(alu_dc),
        .busy(busy), .done(done), .result(result),
        .c_out(c_out), .n_out(n_out), .v_out(v_out), .z_out(z_out)
    );

    // Combinational ALU: DHC flags a low nibble above 9, DC a sum above 0x99.
    always_comb begin
        logic [7:0] bb;
        logic [8:0] sum;
        logic [4:0] lo;
        bb  = alu_mem_bi ? (alu_inv_bi ? ~alu_mi : alu_mi) : 8'h00;
        sum = {1'b0, alu_ai} + {1'b0, bb} + {8'h00, alu_ci};
        lo  = {1'b0, alu_ai[3:0]} + {1'b0, bb[3:0]} + {4'h0, alu_ci};
        alu_out = alu_ai;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_hc  = 1'b0;
        alu_dhc = 1'b0;
        alu_dc  = 1'b0;
        if (alu_op == ALU_ADC) begin
            alu_out = sum[7:0];
            alu_c   = sum[8];
            alu_v   = (alu_ai[7] == bb[7]) && (sum[7] != alu_ai[7]);
            alu_hc  = lo[4];
            alu_dhc = (sum[3:0] > 4'd9);
            alu_dc  = (sum[7:0] > 8'h99);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: packed {result, C, N, V, Z}; decimal computed digit by digit.
    function automatic logic [11:0] ref_op(input logic [7:0] a, input logic [7:0] m,
                                           input logic c, input logic s, input logic d);
        logic [7:0] b, r;
        logic [8:0] bs;
        logic vb, cf;
        int lo, hi, k;
        b  = s ? ~m : m;
        bs = {1'b0, a} + {1'b0, b} + {8'h00, c};
        vb = (a[7] == b[7]) && (bs[7] != a[7]);
        r  = bs[7:0];
        cf = bs[8];
        if (d && !s) begin
            lo = int'(a[3:0]) + int'(m[3:0]) + int'(c);
            k  = 0;
            if (lo > 9) begin lo -= 10; k = 1; end
            hi = int'(a[7:4]) + int'(m[7:4]) + k;
            cf = 1'b0;
            if (hi > 9) begin hi -= 10; cf = 1'b1; end
            r = {hi[3:0], lo[3:0]};
        end else if (d && s) begin
            lo = int'(a[3:0]) - int'(m[3:0]) - (c ? 0 : 1);
            k  = 0;
            if (lo < 0) begin lo += 10; k = 1; end
            hi = int'(a[7:4]) - int'(m[7:4]) - k;
            cf = 1'b1;
            if (hi < 0) begin hi += 10; cf = 1'b0; end
            r = {hi[3:0], lo[3:0]};
        end
        return {r, cf, r[7], vb, (r == 8'h00)};
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("sb_result", result, e[11:4]);
                check("sb_c", c_out, e[3]);
                check("sb_n", n_out, e[2]);
                check("sb_v", v_out, e[1]);
                check("sb_z", z_out, e[0]);
            end
        end
    end

    // Drives one start cycle; returns #1 after the accepting edge with junk on the operand inputs.
    task automatic issue(input logic [7:0] a, input logic [7:0] m, input logic c,
                         input logic s, input logic d, input bit push);
        a_in = a; m_in = m; c_in = c; sbc = s; dec = d; start = 1'b1;
        if (push) exp_q.push_back(ref_op(a, m, c, s, d));
        @(posedge clk); #1;
        start = 1'b0;
        a_in = 8'($urandom); m_in = 8'($urandom); c_in = 1'($urandom);
        sbc = 1'($urandom); dec = 1'($urandom);
    endtask

    task automatic wait_done(input int exp_lat, input string tag);
        int lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                check({tag, "_busy_at_done"}, busy, 0);
                break;
            end
            check({tag, "_busy"}, busy, 1);
        end
        check({tag, "_latency"}, lat, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic check_flags(input string tag, input logic [7:0] r, input logic c,
                               input logic z);
        check({tag, "_res"}, result, r);
        check({tag, "_c"}, c_out, c);
        check({tag, "_z"}, z_out, z);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, {busy, done, result, c_out, n_out, v_out, z_out}, 0);
        check({tag, "_alu"}, {alu_op, alu_ai, alu_mi, alu_ci, alu_mem_bi, alu_inv_bi},
              {ALU_AI, 8'h00, 8'h00, 3'b000});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sbc = 1'b0; dec = 1'b0;
        c_in = 1'b0; a_in = 8'h00; m_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(2, "bin_adc");
        check_flags("bin_adc", 8'hA0, 1'b0, 1'b0);
        check("bin_adc_v", v_out, 1);
        check("bin_adc_n", n_out, 1);

        issue(8'h99, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_done(3, "dec_adc_99");
        check_flags("dec_adc_99", 8'h00, 1'b1, 1'b1);

        issue(8'h09, 8'h09, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_done(3, "dec_adc_hc");
        check_flags("dec_adc_hc", 8'h18, 1'b0, 1'b0);

        issue(8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_done(3, "dec_sbc_both");
        check_flags("dec_sbc_both", 8'h99, 1'b0, 1'b0);

        issue(8'h10, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_done(3, "dec_sbc_lo");
        check_flags("dec_sbc_lo", 8'h09, 1'b1, 1'b0);

        // Second start while BIN is in progress must be dropped.
        issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
        a_in = 8'hFF; m_in = 8'hFF; dec = 1'b1; start = 1'b1;
        @(negedge clk);
        check("ign_busy", busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("ign_done", done, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ign_no_second_done", done, 0);
        end
        check("ign_result", result, 8'h46);
        @(posedge clk); #1;

        // Start coinciding with done is accepted.
        issue(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("b2b_done1", done, 1);
        issue(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(2, "b2b_second");
        check("b2b_result", result, 8'h07);

        // Reset during ADJ.
        issue(8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_done(3, "pre_rst");
        issue(8'h45, 8'h27, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("rst_in_adj_busy", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done(2, "post_rst");
        check("post_rst_result", result, 8'h33);

        // Abort during ADJ.
        issue(8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_done(3, "pre_abort");
        issue(8'h45, 8'h27, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        check("abort_busy", busy, 0);
        check("abort_result", result, 8'h99);
        @(posedge clk); #1;

        for (int n = 0; n < 24; n++) begin
            logic d, s, c;
            logic [7:0] a, m;
            d = 1'($urandom);
            s = 1'($urandom);
            c = 1'($urandom);
            if (d) begin
                a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                m = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
                a = 8'($urandom);
                m = 8'($urandom);
            end
            issue(a, m, c, s, d, 1'b1);
            wait_done(d ? 3 : 2, "rand");
        end

        repeat (3) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
